sha256_pad_sequencer: RTL and testbench
=======================================

# sha256_pad_sequencer

Front-end controller for `sha256_processor`, which hashes only pre-padded 64-byte blocks and latches in DONE until reset. It accepts a raw message byte stream, forwards it to the processor, and generates FIPS 180-4 padding: 0x80, zero fill, then the 64-bit big-endian bit length. It then captures the digest and pulses the processor's reset so the next message can start.

## Interface
- `CNT_W`, default 32: width of the message byte counter. Maximum message length is 2^CNT_W−1 bytes; longer messages wrap the counter modulo 2^CNT_W and are unsupported.
- `clk` in 1: clock.
- `rst` in 1: reset, synchronous, active-high.
- `msg_start` in 1: request a new message; honoured only in IDLE.
- `msg_empty` in 1: sampled with an accepted `msg_start`; 1 means a zero-length message.
- `msg_data` in 8: message byte.
- `msg_valid` in 1: `msg_data` is valid.
- `msg_last` in 1: qualified by `msg_valid`; marks the final message byte.
- `msg_ready` out 1: the sequencer accepts the byte this cycle.
- `proc_start` out 1: one-cycle start pulse to the processor.
- `proc_data` out 8: byte to the processor.
- `proc_valid` out 1: `proc_data` is valid.
- `proc_last` out 1: final padded byte.
- `proc_in_ready` in 1: processor accepts a byte.
- `proc_done` in 1: processor finished.
- `proc_hash` in 256: processor digest.
- `proc_rst` out 1: processor reset; equals `rst` OR (state == PRST).
- `hash_out` out 256: captured digest.
- `hash_valid` out 1: `hash_out` holds the digest of the last completed message.
- `busy` out 1: high in every state except IDLE.

## Operation
- States: IDLE, KICK, DATA, PAD80, ZERO, LEN, WAIT, PRST.
- A byte moves to the processor when `proc_valid && proc_in_ready`.
  - Each transfer increments the 6-bit `pos` counter, which wraps 63→0.
  - Each DATA-state transfer also increments `byte_cnt` (CNT_W bits).
- IDLE:
  - `msg_ready`=0.
  - On `msg_start`: clear `pos`, `byte_cnt` and `hash_valid`; latch `msg_empty`; go to KICK.
- KICK:
  - `proc_start`=1 and `proc_valid`=0 for exactly one cycle.
  - Next state is PAD80 if `msg_empty` was latched, else DATA.
- DATA, combinational pass-through:
  - `proc_data`=`msg_data`, `proc_valid`=`msg_valid`, `msg_ready`=`proc_in_ready`, `proc_last`=0.
  - A transfer with `msg_last`=1 goes to PAD80.
- PAD80:
  - Drive `proc_data`=0x80, `proc_valid`=1.
  - After the transfer, go to LEN if `pos`+1==56, else ZERO.
- ZERO:
  - Drive 0x00, `proc_valid`=1.
  - Leave for LEN after the transfer that makes `pos`==56. ZERO is never entered when `pos` is already 56.
- LEN:
  - Drive 8 bytes of `{byte_cnt, 3'b000}`, zero-extended to 64 bits, MSB byte first. A 3-bit index selects the byte.
  - `proc_last`=1 on the 8th byte only. After that transfer, go to WAIT.
- WAIT:
  - `proc_valid`=0.
  - On `proc_done`=1: `hash_out`←`proc_hash`, `hash_valid`←1, go to PRST.
- PRST:
  - `proc_rst`=1 for one cycle, then go to IDLE.
- `msg_ready`=0 in every state except DATA. `msg_start` is ignored when not in IDLE.
- Padded length is always a multiple of 64 bytes. `pos`==0 after the final LEN byte.

## Timing
- Reset values:
  - `msg_ready`=0, `proc_start`=0, `proc_valid`=0, `proc_last`=0, `proc_data`=0x00, `busy`=0.
  - `proc_rst`=1 while `rst` is high.
  - `hash_out`=0, `hash_valid`=0, state IDLE.
- `msg_start` accepted at edge T → `proc_start` high in cycle T+1 → DATA or PAD80 from T+2.
- The DATA path adds zero latency; `msg_ready` follows `proc_in_ready` in the same cycle.
- Padding proceeds at one byte per cycle while `proc_in_ready`=1. A stall holds `proc_data`, `proc_valid`, `pos` and the LEN index.
- Digest capture happens on the edge where `proc_done` is seen in WAIT. `hash_valid` rises the cycle after, with `proc_rst` high in that same cycle. IDLE follows one cycle later.
- `hash_valid` stays high until the next accepted `msg_start`. `hash_out` is held until the next capture.
- Reset mid-message: all state is abandoned, and `proc_rst` is asserted with `rst` so the processor is also cleared.

## Test plan
- "abc" (61 62 63):
  - Padded stream is 61 62 63 80, 52×00, then 00 00 00 00 00 00 00 18; 64 bytes total.
  - `proc_last` is on byte 63.
  - `hash_out`=ba7816bf…f20015ad.
- Empty message (`msg_empty`=1):
  - Stream is 80, 55×00, 8×00.
  - `hash_out`=e3b0c442…7852b855.
- 55-byte message: 0x80 at `pos` 55, no ZERO state, length 0x1B8, exactly 64 bytes.
- 56-byte message: 0x80, 63×00, 8 length bytes (0x1C0); 128 bytes total, two blocks.
- Random `proc_in_ready` and `msg_valid` stalls on a 200-byte message:
  - No byte is dropped or duplicated; 256 bytes are sent.
  - Digest matches the reference model.
  - `msg_start` pulses while busy are ignored.
- `rst` asserted mid-DATA:
  - `proc_rst`=1, all outputs return to reset values.
  - A following "abc" message hashes correctly.

Source files
------------

// File: rtl/sha256_pad_sequencer.sv
`timescale 1ns/1ps
// sha256_pad_sequencer: feeds a raw message byte stream to sha256_processor,
// appends the 0x80 / zero-fill / 64-bit length padding, captures the digest
// and then pulses the processor reset so the next message can start clean.
module sha256_pad_sequencer #(
  parameter int CNT_W = 32
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         msg_start,
  input  logic         msg_empty,
  input  logic [7:0]   msg_data,
  input  logic         msg_valid,
  input  logic         msg_last,
  output logic         msg_ready,
  output logic         proc_start,
  output logic [7:0]   proc_data,
  output logic         proc_valid,
  output logic         proc_last,
  input  logic         proc_in_ready,
  input  logic         proc_done,
  input  logic [255:0] proc_hash,
  output logic         proc_rst,
  output logic [255:0] hash_out,
  output logic         hash_valid,
  output logic         busy
);

  typedef enum logic [2:0] {
    IDLE, KICK, DATA, PAD80, ZERO, LEN, WAIT, PRST
  } state_t;

  state_t             state;
  state_t             state_next;
  logic [5:0]         pos;
  logic [5:0]         pos_inc;
  logic [CNT_W-1:0]   byte_cnt;
  logic               empty_q;
  logic [2:0]         len_idx;
  logic [5:0]         len_shift;
  logic [63:0]        bit_len;
  logic [63:0]        bit_len_shifted;
  logic [7:0]         len_byte;
  logic               xfer;

  assign pos_inc         = pos + 6'd1;
  assign bit_len         = 64'({byte_cnt, 3'b000});
  assign len_shift       = {3'd7 - len_idx, 3'b000};
  assign bit_len_shifted = bit_len >> len_shift;
  assign len_byte        = bit_len_shifted[7:0];
  assign xfer            = proc_valid && proc_in_ready;
  assign proc_rst        = rst | (state == PRST);
  assign busy            = (state != IDLE);

  // State register.
  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_next;
  end

  // Next-state selection and the byte mux toward the processor.
  always_comb begin
    state_next = state;
    msg_ready  = 1'b0;
    proc_start = 1'b0;
    proc_data  = 8'h00;
    proc_valid = 1'b0;
    proc_last  = 1'b0;
    case (state)
      IDLE: begin
        if (msg_start) state_next = KICK;
      end
      KICK: begin
        proc_start = 1'b1;
        state_next = empty_q ? PAD80 : DATA;
      end
      DATA: begin
        proc_data  = msg_data;
        proc_valid = msg_valid;
        msg_ready  = proc_in_ready;
        if (msg_valid && proc_in_ready && msg_last) state_next = PAD80;
      end
      PAD80: begin
        proc_data  = 8'h80;
        proc_valid = 1'b1;
        if (proc_in_ready) state_next = (pos_inc == 6'd56) ? LEN : ZERO;
      end
      ZERO: begin
        proc_valid = 1'b1;
        if (proc_in_ready && pos_inc == 6'd56) state_next = LEN;
      end
      LEN: begin
        proc_data  = len_byte;
        proc_valid = 1'b1;
        proc_last  = (len_idx == 3'd7);
        if (proc_in_ready && len_idx == 3'd7) state_next = WAIT;
      end
      WAIT: begin
        if (proc_done) state_next = PRST;
      end
      PRST: begin
        state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  // Block position, message length, length-byte index and digest capture.
  always_ff @(posedge clk) begin
    if (rst) begin
      pos        <= 6'd0;
      byte_cnt   <= '0;
      empty_q    <= 1'b0;
      len_idx    <= 3'd0;
      hash_out   <= '0;
      hash_valid <= 1'b0;
    end else begin
      if (state == IDLE && msg_start) begin
        pos        <= 6'd0;
        byte_cnt   <= '0;
        len_idx    <= 3'd0;
        empty_q    <= msg_empty;
        hash_valid <= 1'b0;
      end
      if (xfer) pos <= pos_inc;
      if (xfer && state == DATA) byte_cnt <= byte_cnt + CNT_W'(1);
      if (xfer && state == LEN) len_idx <= len_idx + 3'd1;
      if (state == WAIT && proc_done) begin
        hash_out   <= proc_hash;
        hash_valid <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_sha256_pad_sequencer.sv
`timescale 1ns/1ps
// Directed bench for sha256_pad_sequencer with a behavioural SHA-256
// processor model on the downstream side.
module tb_sha256_pad_sequencer;

  localparam logic [255:0] H_INIT =
    256'h6a09e667bb67ae853c6ef372a54ff53a510e527f9b05688c1f83d9ab5be0cd19;
  localparam logic [255:0] DIGEST_ABC =
    256'hba7816bf8f01cfea414140de5dae2223b00361a396177a9cb410ff61f20015ad;
  localparam logic [255:0] DIGEST_EMPTY =
    256'he3b0c44298fc1c149afbf4c8996fb92427ae41e4649b934ca495991b7852b855;
  localparam logic [31:0] K [64] = '{
    32'h428a2f98, 32'h71374491, 32'hb5c0fbcf, 32'he9b5dba5, 32'h3956c25b, 32'h59f111f1, 32'h923f82a4, 32'hab1c5ed5,
    32'hd807aa98, 32'h12835b01, 32'h243185be, 32'h550c7dc3, 32'h72be5d74, 32'h80deb1fe, 32'h9bdc06a7, 32'hc19bf174,
    32'he49b69c1, 32'hefbe4786, 32'h0fc19dc6, 32'h240ca1cc, 32'h2de92c6f, 32'h4a7484aa, 32'h5cb0a9dc, 32'h76f988da,
    32'h983e5152, 32'ha831c66d, 32'hb00327c8, 32'hbf597fc7, 32'hc6e00bf3, 32'hd5a79147, 32'h06ca6351, 32'h14292967,
    32'h27b70a85, 32'h2e1b2138, 32'h4d2c6dfc, 32'h53380d13, 32'h650a7354, 32'h766a0abb, 32'h81c2c92e, 32'h92722c85,
    32'ha2bfe8a1, 32'ha81a664b, 32'hc24b8b70, 32'hc76c51a3, 32'hd192e819, 32'hd6990624, 32'hf40e3585, 32'h106aa070,
    32'h19a4c116, 32'h1e376c08, 32'h2748774c, 32'h34b0bcb5, 32'h391c0cb3, 32'h4ed8aa4a, 32'h5b9cca4f, 32'h682e6ff3,
    32'h748f82ee, 32'h78a5636f, 32'h84c87814, 32'h8cc70208, 32'h90befffa, 32'ha4506ceb, 32'hbef9a3f7, 32'hc67178f2
  };

  logic         clk;
  logic         rst;
  logic         msg_start;
  logic         msg_empty;
  logic [7:0]   msg_data;
  logic         msg_valid;
  logic         msg_last;
  logic         msg_ready;
  logic         proc_start;
  logic [7:0]   proc_data;
  logic         proc_valid;
  logic         proc_last;
  logic         proc_in_ready;
  logic         proc_done;
  logic [255:0] proc_hash;
  logic         proc_rst;
  logic [255:0] hash_out;
  logic         hash_valid;
  logic         busy;

  int           vectors = 0;
  int           miscompares = 0;
  bit           stall_mode = 1'b0;
  logic [7:0]   rx_q [$];
  int           last_cnt;
  int           last_idx;
  int           start_cnt;
  logic [255:0] h_state;
  logic [511:0] blk;
  int           bidx;
  int           done_cnt;
  bit           done_flag;
  logic [255:0] prev_hash;

  sha256_pad_sequencer dut (
    .clk(clk), .rst(rst),
    .msg_start(msg_start), .msg_empty(msg_empty), .msg_data(msg_data),
    .msg_valid(msg_valid), .msg_last(msg_last), .msg_ready(msg_ready),
    .proc_start(proc_start), .proc_data(proc_data), .proc_valid(proc_valid),
    .proc_last(proc_last), .proc_in_ready(proc_in_ready), .proc_done(proc_done),
    .proc_hash(proc_hash), .proc_rst(proc_rst), .hash_out(hash_out),
    .hash_valid(hash_valid), .busy(busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [31:0] ror(input logic [31:0] x, input int n);
    return (x >> n) | (x << (32 - n));
  endfunction

  function automatic logic [255:0] compress(input logic [255:0] hin, input logic [511:0] b);
    logic [31:0] w [64];
    logic [31:0] a, bb, c, d, e, f, g, h, s0, s1, t1, t2;
    for (int t = 0; t < 16; t++) w[t] = b[511 - 32*t -: 32];
    for (int t = 16; t < 64; t++) begin
      s0 = ror(w[t-15], 7) ^ ror(w[t-15], 18) ^ (w[t-15] >> 3);
      s1 = ror(w[t-2], 17) ^ ror(w[t-2], 19) ^ (w[t-2] >> 10);
      w[t] = w[t-16] + s0 + w[t-7] + s1;
    end
    {a, bb, c, d, e, f, g, h} = hin;
    for (int t = 0; t < 64; t++) begin
      s1 = ror(e, 6) ^ ror(e, 11) ^ ror(e, 25);
      t1 = h + s1 + ((e & f) ^ (~e & g)) + K[t] + w[t];
      s0 = ror(a, 2) ^ ror(a, 13) ^ ror(a, 22);
      t2 = s0 + ((a & bb) ^ (a & c) ^ (bb & c));
      h = g; g = f; f = e; e = d + t1;
      d = c; c = bb; bb = a; a = t1 + t2;
    end
    return {hin[255:224] + a, hin[223:192] + bb, hin[191:160] + c, hin[159:128] + d,
            hin[127:96] + e, hin[95:64] + f, hin[63:32] + g, hin[31:0] + h};
  endfunction

  function automatic void build_pad(input logic [7:0] m [$], output logic [7:0] p [$]);
    logic [63:0] bit_len;
    bit_len = 64'(m.size()) * 64'd8;
    p = m;
    p.push_back(8'h80);
    while (p.size() % 64 != 56) p.push_back(8'h00);
    for (int k = 7; k >= 0; k--) p.push_back(bit_len[8*k +: 8]);
  endfunction

  function automatic logic [255:0] sha_ref(input logic [7:0] m [$]);
    logic [7:0]   p [$];
    logic [255:0] hv;
    logic [511:0] b;
    build_pad(m, p);
    hv = H_INIT;
    b  = '0;
    for (int n = 0; n < p.size() / 64; n++) begin
      for (int k = 0; k < 64; k++) b = {b[503:0], p[n*64 + k]};
      hv = compress(hv, b);
    end
    return hv;
  endfunction

  task automatic check_output(input string tag, input logic [255:0] observed, input logic [255:0] expected);
    vectors++;
    assert (observed === expected) else begin
      miscompares++;
      $error("[TB] FAIL %s: observed %h expected %h", tag, observed, expected);
    end
  endtask

  // Processor model: drives its outputs on the falling edge, samples the
  // sequencer just before the rising edge, hashes each 64-byte block.
  initial begin
    proc_in_ready = 1'b1;
    proc_done     = 1'b0;
    proc_hash     = '0;
    h_state       = H_INIT;
    blk           = '0;
    bidx          = 0;
    done_cnt      = 0;
    done_flag     = 1'b0;
    forever begin
      @(negedge clk);
      proc_in_ready = stall_mode ? ($urandom_range(0, 3) != 0) : 1'b1;
      proc_done     = done_flag;
      proc_hash     = done_flag ? h_state : '0;
      #4;
      if (proc_rst) begin
        h_state   = H_INIT;
        bidx      = 0;
        done_cnt  = 0;
        done_flag = 1'b0;
      end else begin
        if (proc_start) begin
          h_state = H_INIT;
          bidx    = 0;
          start_cnt++;
        end
        if (proc_valid && proc_in_ready) begin
          rx_q.push_back(proc_data);
          blk = {blk[503:0], proc_data};
          bidx++;
          if (bidx == 64) begin
            h_state = compress(h_state, blk);
            bidx    = 0;
          end
          if (proc_last) begin
            last_cnt++;
            last_idx = rx_q.size() - 1;
            done_cnt = 3;
          end
        end else if (done_cnt > 0) begin
          done_cnt--;
          if (done_cnt == 0) done_flag = 1'b1;
        end
      end
    end
  end

  // One whole message: start handshake, byte feed, digest wait, stream checks.
  task automatic apply_stimulus(input string name, input logic [7:0] msg [$], input bit empty,
                                input bit stall, input logic [255:0] exp_digest);
    logic [7:0] exp_q [$];
    int         i;
    int         cycles;
    int         mism;
    bit         got;
    rx_q.delete();
    last_cnt   = 0;
    last_idx   = -1;
    start_cnt  = 0;
    stall_mode = stall;
    @(negedge clk);
    msg_start = 1'b1;
    msg_empty = empty;
    @(negedge clk);
    msg_start = 1'b0;
    msg_empty = 1'b0;
    #4;
    check_output({name, " proc_start"}, 256'(proc_start), 256'd1);
    check_output({name, " kick_valid"}, 256'(proc_valid), 256'd0);
    check_output({name, " hash_valid_clr"}, 256'(hash_valid), 256'd0);
    check_output({name, " hash_held"}, hash_out, prev_hash);
    i = 0;
    cycles = 0;
    while (i < msg.size() && cycles < 5000) begin
      @(negedge clk);
      msg_valid = stall ? ($urandom_range(0, 2) != 0) : 1'b1;
      msg_data  = msg[i];
      msg_last  = (i == msg.size() - 1);
      msg_start = stall ? ($urandom_range(0, 7) == 0) : 1'b0;
      #4;
      if (msg_valid && msg_ready) i++;
      cycles++;
    end
    check_output({name, " feed_count"}, 256'(i), 256'(msg.size()));
    @(negedge clk);
    msg_valid = 1'b0;
    msg_last  = 1'b0;
    msg_data  = 8'h00;
    msg_start = 1'b0;
    got = 1'b0;
    cycles = 0;
    while (!got && cycles < 2000) begin
      #4;
      got = (hash_valid === 1'b1);
      cycles++;
      if (!got) begin
        @(negedge clk);
        msg_start = stall ? ($urandom_range(0, 7) == 0) : 1'b0;
      end
    end
    check_output({name, " done_seen"}, 256'(got), 256'd1);
    check_output({name, " prst_pulse"}, 256'(proc_rst), 256'd1);
    check_output({name, " digest"}, hash_out, exp_digest);
    @(negedge clk);
    msg_start = 1'b0;
    #4;
    check_output({name, " idle_busy"}, 256'(busy), 256'd0);
    check_output({name, " idle_hash_valid"}, 256'(hash_valid), 256'd1);
    check_output({name, " idle_proc_rst"}, 256'(proc_rst), 256'd0);
    build_pad(msg, exp_q);
    mism = 0;
    for (int k = 0; k < exp_q.size() && k < rx_q.size(); k++)
      if (rx_q[k] !== exp_q[k]) mism++;
    check_output({name, " stream_len"}, 256'(rx_q.size()), 256'(exp_q.size()));
    check_output({name, " stream_bytes_wrong"}, 256'(mism), 256'd0);
    check_output({name, " last_count"}, 256'(last_cnt), 256'd1);
    check_output({name, " last_index"}, 256'(last_idx), 256'(exp_q.size() - 1));
    check_output({name, " start_count"}, 256'(start_cnt), 256'd1);
    prev_hash  = exp_digest;
    stall_mode = 1'b0;
  endtask

  // Values every output must show while the sequencer sits in reset.
  task automatic check_reset_state(input string name);
    check_output({name, " msg_ready"}, 256'(msg_ready), 256'd0);
    check_output({name, " proc_start"}, 256'(proc_start), 256'd0);
    check_output({name, " proc_valid"}, 256'(proc_valid), 256'd0);
    check_output({name, " proc_last"}, 256'(proc_last), 256'd0);
    check_output({name, " proc_data"}, 256'(proc_data), 256'd0);
    check_output({name, " busy"}, 256'(busy), 256'd0);
    check_output({name, " proc_rst"}, 256'(proc_rst), 256'd1);
    check_output({name, " hash_out"}, hash_out, 256'd0);
    check_output({name, " hash_valid"}, 256'(hash_valid), 256'd0);
  endtask

  // Directed sequence of messages.
  initial begin
    logic [7:0] m [$];
    int         i;
    int         cycles;
    rst       = 1'b1;
    msg_start = 1'b0;
    msg_empty = 1'b0;
    msg_data  = 8'h00;
    msg_valid = 1'b0;
    msg_last  = 1'b0;
    prev_hash = '0;
    repeat (2) @(negedge clk);
    #4;
    check_reset_state("reset");
    @(negedge clk);
    rst = 1'b0;

    m = {8'h61, 8'h62, 8'h63};
    apply_stimulus("abc", m, 1'b0, 1'b0, DIGEST_ABC);

    m.delete();
    apply_stimulus("empty", m, 1'b1, 1'b0, DIGEST_EMPTY);

    m.delete();
    for (int k = 0; k < 55; k++) m.push_back(8'(k * 7 + 3));
    apply_stimulus("len55", m, 1'b0, 1'b0, sha_ref(m));

    m.delete();
    for (int k = 0; k < 56; k++) m.push_back(8'(k * 11 + 5));
    apply_stimulus("len56", m, 1'b0, 1'b0, sha_ref(m));

    m.delete();
    for (int k = 0; k < 200; k++) m.push_back(8'($urandom_range(0, 255)));
    apply_stimulus("len200_stall", m, 1'b0, 1'b1, sha_ref(m));

    // Abandon a message halfway through its data phase.
    m.delete();
    for (int k = 0; k < 20; k++) m.push_back(8'(k + 1));
    @(negedge clk);
    msg_start = 1'b1;
    msg_empty = 1'b0;
    @(negedge clk);
    msg_start = 1'b0;
    i = 0;
    cycles = 0;
    while (i < 10 && cycles < 100) begin
      @(negedge clk);
      msg_valid = 1'b1;
      msg_data  = m[i];
      msg_last  = 1'b0;
      #4;
      if (msg_valid && msg_ready) i++;
      cycles++;
    end
    check_output("midrst busy_before", 256'(busy), 256'd1);
    @(negedge clk);
    rst       = 1'b1;
    msg_valid = 1'b0;
    #4;
    check_output("midrst proc_rst_comb", 256'(proc_rst), 256'd1);
    @(negedge clk);
    #4;
    check_reset_state("midrst");
    @(negedge clk);
    rst = 1'b0;
    prev_hash = '0;

    m = {8'h61, 8'h62, 8'h63};
    apply_stimulus("abc_after_rst", m, 1'b0, 1'b0, DIGEST_ABC);

    $display("[TB] == %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
